// File: rtl/fir_tap_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_sequencer_if
// Brief    : Sample/coefficient/result bundle between the audio path, the
//            equalizer tap generator and the FIR tap sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_tap_sequencer_if #(
  parameter int DW = 16,
  parameter int CW = 16
);
  logic signed [DW-1:0] sample_in;
  logic                 sample_valid;
  logic [7:0]           tapnum;
  logic signed [CW-1:0] desiredTap;
  logic signed [DW-1:0] sample_out;
  logic                 out_valid;
  logic                 busy;
  logic                 drop_err;

  modport master (
    output sample_in, sample_valid, desiredTap,
    input  tapnum, sample_out, out_valid, busy, drop_err
  );

  modport slave (
    input  sample_in, sample_valid, desiredTap,
    output tapnum, sample_out, out_valid, busy, drop_err
  );
endinterface
`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_sequencer
// Brief    : Circular-delay-line FIR that walks all taps with one MAC per
//            cycle and emits a rounded, saturated sample per input.
// Revision : 1.0 - initial release
// ============================================================================
module fir_tap_sequencer #(
  parameter int NTAPS = 32,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACCW  = 40
) (
  input  wire logic            clk,
  input  wire logic            reset,
  fir_tap_sequencer_if.slave   bus
);

  localparam int AW = $clog2(NTAPS);
  localparam logic signed [ACCW-1:0] C_RND     = ACCW'(1) << 14;
  localparam logic signed [ACCW-1:0] C_SAT_MAX = ACCW'((1 << (DW-1)) - 1);
  localparam logic signed [ACCW-1:0] C_SAT_MIN = ~C_SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         base_q, base_d;
  logic [AW-1:0]         k_q, k_d;
  logic [AW-1:0]         didx_q, didx_d;
  logic                  mac_en_q, mac_en_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [DW-1:0]  delay_q [NTAPS];
  logic signed [DW-1:0]  delay_d [NTAPS];
  logic signed [DW-1:0]  sample_out_q, sample_out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  drop_err_q, drop_err_d;

  logic                      w_accept;
  logic signed [DW-1:0]      w_tap_sample;
  logic signed [DW+CW-1:0]   w_prod;
  logic signed [ACCW-1:0]    w_prod_ext;
  logic signed [ACCW-1:0]    w_acc_rnd;
  logic signed [ACCW-1:0]    w_acc_shr;

  // busy also covers the out_valid cycle, so a sample there is dropped
  assign w_accept     = bus.sample_valid && !busy_q;
  assign w_tap_sample = delay_q[didx_q];
  assign w_prod       = $signed({{CW{w_tap_sample[DW-1]}}, w_tap_sample}) *
                        $signed({{DW{bus.desiredTap[CW-1]}}, bus.desiredTap});
  assign w_prod_ext   = {{(ACCW-DW-CW){w_prod[DW+CW-1]}}, w_prod};
  assign w_acc_rnd    = acc_q + C_RND;
  assign w_acc_shr    = w_acc_rnd >>> 15;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    base_d       = base_q;
    k_d          = k_q;
    didx_d       = didx_q;
    mac_en_d     = 1'b0;
    acc_d        = acc_q;
    delay_d      = delay_q;
    sample_out_d = sample_out_q;
    out_valid_d  = 1'b0;
    busy_d       = busy_q;
    drop_err_d   = drop_err_q;

    if (bus.sample_valid && busy_q) begin
      drop_err_d = 1'b1;
    end

    // Coefficient for the previously issued tap is on desiredTap now
    if (mac_en_q) begin
      acc_d = acc_q + w_prod_ext;
    end

    if (w_accept) begin
      busy_d = 1'b1;
    end else if (out_valid_q) begin
      busy_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          delay_d[wptr_q] = bus.sample_in;
          base_d          = wptr_q;
          wptr_d          = wptr_q + 1'b1;
          acc_d           = '0;
          k_d             = '0;
          state_d         = S_RUN;
        end
      end
      S_RUN: begin
        didx_d   = base_q - k_q;
        mac_en_d = 1'b1;
        k_d      = k_q + 1'b1;
        if (k_q == AW'(NTAPS-1)) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (w_acc_shr > C_SAT_MAX) begin
          sample_out_d = C_SAT_MAX[DW-1:0];
        end else if (w_acc_shr < C_SAT_MIN) begin
          sample_out_d = C_SAT_MIN[DW-1:0];
        end else begin
          sample_out_d = w_acc_shr[DW-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      base_q       <= '0;
      k_q          <= '0;
      didx_q       <= '0;
      mac_en_q     <= 1'b0;
      acc_q        <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      drop_err_q   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        delay_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      base_q       <= base_d;
      k_q          <= k_d;
      didx_q       <= didx_d;
      mac_en_q     <= mac_en_d;
      acc_q        <= acc_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      drop_err_q   <= drop_err_d;
      delay_q      <= delay_d;
    end
  end

  assign bus.tapnum     = (state_q == S_RUN) ? 8'(k_q) : 8'd0;
  assign bus.sample_out = sample_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.drop_err   = drop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_tap_sequencer
// Brief    : Directed and random stimulus against a sum-of-products model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_tap_sequencer;
  localparam int NTAPS = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_tap_sequencer_if #(.DW(16), .CW(16)) bus ();

  fir_tap_sequencer #(
    .NTAPS(NTAPS), .DW(16), .CW(16), .ACCW(40)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic signed [15:0] coef [NTAPS];
  logic signed [15:0] hist [NTAPS];   // hist[0] = newest accepted sample
  int total = 0;
  int bad   = 0;

  // Tap generator: one-cycle latency lookup
  always @(posedge clk) bus.desiredTap <= coef[bus.tapnum[4:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < NTAPS; i++) hist[i] = '0;
  endtask

  task automatic push_hist(input logic signed [15:0] s);
    for (int i = NTAPS-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
  endtask

  function automatic logic [15:0] model_y();
    longint acc = 0;
    longint y;
    for (int k = 0; k < NTAPS; k++) acc += longint'(coef[k]) * longint'(hist[k]);
    y = (acc + 64'sd16384) >>> 15;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return 16'(y);
  endfunction

  // One accepted sample, optional extra strobe at cycle drop_c (0 = none)
  task automatic run_one(input logic [15:0] s, input int drop_c, output logic [15:0] got);
    logic [15:0] expv;
    int nout, lat;
    bit tap_ok;
    logic b_at, b_after;
    @(negedge clk);
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    push_hist(s);
    expv = model_y();
    nout = 0; lat = -1; tap_ok = 1'b1; got = '0; b_at = 1'b0; b_after = 1'b1;
    for (int c = 1; c <= NTAPS + 8; c++) begin
      @(negedge clk);
      if (c == drop_c) begin
        bus.sample_valid = 1'b1;
        bus.sample_in    = 16'($urandom);
      end else begin
        bus.sample_valid = 1'b0;
      end
      if (bus.tapnum !== ((c <= NTAPS) ? 8'(c-1) : 8'd0)) tap_ok = 1'b0;
      if (bus.out_valid === 1'b1) begin
        nout++;
        if (lat < 0) begin
          lat = c;
          got = bus.sample_out;
        end
      end
      if (c == NTAPS + 3) b_at = bus.busy;
      if (c == NTAPS + 4) b_after = bus.busy;
    end
    check("tapnum_seq", 32'(tap_ok), 32'd1);
    check("out_count", nout, 1);
    check("latency", lat, NTAPS + 3);
    check("sample_out", got, expv);
    check("busy_at_out", 32'(b_at), 32'd1);
    check("busy_after_out", 32'(b_after), 32'd0);
  endtask

  initial begin
    logic [15:0] got;
    int nout;
    reset            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    for (int k = 0; k < NTAPS; k++) coef[k] = 16'(4 + k);
    clear_hist();
    repeat (3) @(negedge clk);
    check("rst_tapnum", bus.tapnum, 0);
    check("rst_sample_out", bus.sample_out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_drop_err", bus.drop_err, 0);
    reset = 1'b1;

    // Impulse response: 4, 5, ... 35
    run_one(16'h7FFF, 0, got);
    check("impulse_first", got, 32'd4);
    for (int i = 1; i < NTAPS; i++) run_one(16'h0000, 0, got);
    check("impulse_last", got, 32'd35);

    // Pointer wrap: 33rd output after the impulse is zero
    for (int i = 0; i < NTAPS; i++) begin
      run_one(16'h0000, 0, got);
      if (i == 0) check("wrap_zero", got, 32'd0);
    end
    check("no_drop_yet", bus.drop_err, 0);

    // Drop during busy
    run_one(16'h7FFF, 5, got);
    check("drop_err_set", bus.drop_err, 1);
    check("drop_impulse", got, 32'd4);
    run_one(16'h0000, 0, got);
    check("drop_next", got, 32'd5);

    // Reset mid-run at k = 10
    @(negedge clk);
    bus.sample_in    = 16'h1234;
    bus.sample_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
    end
    check("tap_before_reset", bus.tapnum, 10);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_hist();
    check("midrst_tapnum", bus.tapnum, 0);
    check("midrst_sample_out", bus.sample_out, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_drop_err", bus.drop_err, 0);
    nout = 0;
    for (int c = 0; c < NTAPS + 8; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) nout++;
    end
    check("midrst_no_out", nout, 0);
    run_one(16'h7FFF, 0, got);
    check("midrst_impulse", got, 32'd4);

    // Positive saturation
    for (int k = 0; k < NTAPS; k++) coef[k] = 16'h7FFF;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clear_hist();
    for (int i = 0; i < NTAPS; i++) begin
      run_one(16'h7FFF, 0, got);
      if (i == 0) check("possat_first", got, 32'h7FFE);
    end
    check("possat_last", got, 32'h7FFF);

    // Negative saturation, continuing from full positive history
    for (int i = 0; i < NTAPS; i++) run_one(16'h8000, 0, got);
    check("negsat_last", got, 32'h8000);

    // Random coefficients and samples
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) begin
        for (int k = 0; k < NTAPS; k++) coef[k] = 16'($urandom);
      end
      run_one(16'($urandom), 0, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
